// File: rtl/pkt_rd_framer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pkt_rd_framer : strips length headers off packet FIFO words, streams payload (rev 1.0)
// ----------------------------------------------------------------------------
module pkt_rd_framer #(
  parameter int WIDTH   = 256,
  parameter int MOD_W   = 5,
  parameter int LEN_W   = 16,
  parameter int MAX_LEN = 9600
) (
  input  logic             clk,
  input  logic             reset_,
  output logic             fifo_rden,
  input  logic [WIDTH-1:0] fifo_dout,
  input  logic             fifo_rdempty,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic [WIDTH-1:0] tx_data,
  output logic             tx_sop,
  output logic             tx_eop,
  output logic [MOD_W-1:0] tx_mod,
  output logic             len_err
);
  localparam int              WL_W      = LEN_W - MOD_W + 1;
  localparam int              BYTES     = WIDTH / 8;
  localparam logic [LEN_W-1:0] MAX_LEN_V = LEN_W'(MAX_LEN);
  localparam logic [LEN_W:0]   ROUND_UP  = (LEN_W + 1)'(BYTES - 1);

  logic [1:0]       occ;
  logic             inflight;
  logic             hdr_exp;
  logic             first;
  logic [WL_W-1:0]  words_left;
  logic [MOD_W-1:0] mod_q;

  // Second buffer slot; the head slot is the tx_* register set itself.
  logic [WIDTH-1:0] b1_data;
  logic             b1_sop;
  logic             b1_eop;
  logic [MOD_W-1:0] b1_mod;

  logic             pop;
  logic             push;
  logic             hdr_ok;
  logic             hdr_bad;
  logic             is_eop;
  logic [1:0]       credit;
  logic [LEN_W-1:0] hdr_len;
  logic [LEN_W:0]   len_rnd;
  logic [MOD_W-1:0] new_mod;

  always_comb begin
    tx_valid  = (occ != 2'd0);
    pop       = tx_valid && tx_ready;
    // Words already requested count against buffer space, so a read is only
    // issued when its data is guaranteed a slot.
    credit    = occ - {1'b0, pop} + {1'b0, inflight};
    fifo_rden = reset_ && !fifo_rdempty && (credit < 2'd2);
    hdr_len   = fifo_dout[LEN_W-1:0];
    hdr_ok    = inflight && hdr_exp && (hdr_len != '0) && (hdr_len <= MAX_LEN_V);
    hdr_bad   = inflight && hdr_exp && !hdr_ok;
    push      = inflight && !hdr_exp;
    is_eop    = (words_left == WL_W'(1));
    new_mod   = is_eop ? mod_q : '0;
    len_rnd   = {1'b0, hdr_len} + ROUND_UP;
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      inflight   <= 1'b0;
      hdr_exp    <= 1'b1;
      first      <= 1'b0;
      words_left <= '0;
      mod_q      <= '0;
      len_err    <= 1'b0;
    end else begin
      inflight <= fifo_rden;
      len_err  <= hdr_bad;
      if (hdr_ok) begin
        words_left <= WL_W'(len_rnd >> MOD_W);
        mod_q      <= hdr_len[MOD_W-1:0];
        first      <= 1'b1;
        hdr_exp    <= 1'b0;
      end else if (push) begin
        first      <= 1'b0;
        words_left <= words_left - WL_W'(1);
        if (is_eop) begin
          hdr_exp <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      occ     <= 2'd0;
      tx_data <= '0;
      tx_sop  <= 1'b0;
      tx_eop  <= 1'b0;
      tx_mod  <= '0;
      b1_data <= '0;
      b1_sop  <= 1'b0;
      b1_eop  <= 1'b0;
      b1_mod  <= '0;
    end else begin
      // Head loads the incoming word when it would otherwise be empty,
      // and shifts up from slot 1 when popped with slot 1 occupied.
      if (push && ((occ == 2'd0) || ((occ == 2'd1) && pop))) begin
        tx_data <= fifo_dout;
        tx_sop  <= first;
        tx_eop  <= is_eop;
        tx_mod  <= new_mod;
      end else if (pop && (occ == 2'd2)) begin
        tx_data <= b1_data;
        tx_sop  <= b1_sop;
        tx_eop  <= b1_eop;
        tx_mod  <= b1_mod;
      end
      if (push && (((occ == 2'd1) && !pop) || ((occ == 2'd2) && pop))) begin
        b1_data <= fifo_dout;
        b1_sop  <= first;
        b1_eop  <= is_eop;
        b1_mod  <= new_mod;
      end
      occ <= occ + {1'b0, push} - {1'b0, pop};
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_pkt_rd_framer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_pkt_rd_framer : randomized bench checked against a packet-level reference model (rev 1.0)
// ----------------------------------------------------------------------------
module tb_pkt_rd_framer;
  localparam int WIDTH   = 256;
  localparam int MOD_W   = 5;
  localparam int LEN_W   = 16;
  localparam int MAX_LEN = 9600;
  localparam int BYTES   = WIDTH / 8;

  typedef struct packed {
    logic [WIDTH-1:0] d;
    logic             sop;
    logic             eop;
    logic [MOD_W-1:0] mod;
  } word_t;

  logic             clk = 1'b0;
  logic             reset_ = 1'b1;
  logic             fifo_rden;
  logic [WIDTH-1:0] fifo_dout = '0;
  logic             fifo_rdempty = 1'b1;
  logic             tx_valid;
  logic             tx_ready = 1'b0;
  logic [WIDTH-1:0] tx_data;
  logic             tx_sop;
  logic             tx_eop;
  logic [MOD_W-1:0] tx_mod;
  logic             len_err;
  logic             gap = 1'b0;

  word_t            exp_q[$];
  word_t            got[$];
  logic [WIDTH-1:0] fifo_q[$];
  int               acc_cyc[$];
  int               cyc = 0;
  int               n_checks = 0;
  int               n_pass = 0;
  int               first_rden = -1;
  int               first_valid = -1;
  int               err_cycles = 0;
  int               err_rises = 0;
  logic             err_prev = 1'b0;
  bit               rd_empty_viol = 1'b0;

  pkt_rd_framer #(
    .WIDTH(WIDTH), .MOD_W(MOD_W), .LEN_W(LEN_W), .MAX_LEN(MAX_LEN)
  ) dut (
    .clk(clk), .reset_(reset_),
    .fifo_rden(fifo_rden), .fifo_dout(fifo_dout), .fifo_rdempty(fifo_rdempty),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .tx_sop(tx_sop), .tx_eop(tx_eop), .tx_mod(tx_mod), .len_err(len_err)
  );

  always #5 clk = ~clk;

  // Registered-read FIFO: data appears the cycle after the read request.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset_ && fifo_rden && !fifo_rdempty && fifo_q.size() > 0)
      fifo_dout <= fifo_q.pop_front();
  end

  always @(negedge clk) begin
    #1;
    fifo_rdempty = (fifo_q.size() == 0) || gap;
  end

  // Recorder only: captures accepted words and event timing for the tests.
  always @(negedge clk) begin
    #3;
    if (reset_) begin
      if (fifo_rden && fifo_rdempty) rd_empty_viol = 1'b1;
      if (fifo_rden && first_rden < 0) first_rden = cyc;
      if (tx_valid && first_valid < 0) first_valid = cyc;
      if (tx_valid && tx_ready) begin
        got.push_back({tx_data, tx_sop, tx_eop, tx_mod});
        acc_cyc.push_back(cyc);
      end
      if (len_err) err_cycles++;
      if (len_err && !err_prev) err_rises++;
      err_prev = len_err;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [WIDTH-1:0] rand_word();
    logic [WIDTH-1:0] w;
    for (int i = 0; i < WIDTH / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  // Reference model: a legal packet of len bytes yields ceil(len/BYTES) words,
  // sop on the first, eop on the last, mod = len % BYTES on the last.
  task automatic push_pkt(input int len);
    logic [WIDTH-1:0] h;
    int nw;
    h = rand_word();
    h[LEN_W-1:0] = len[LEN_W-1:0];
    fifo_q.push_back(h);
    if (len >= 1 && len <= MAX_LEN) begin
      nw = (len + BYTES - 1) / BYTES;
      for (int i = 0; i < nw; i++) begin
        word_t e;
        e.d   = rand_word();
        e.sop = (i == 0);
        e.eop = (i == nw - 1);
        e.mod = e.eop ? MOD_W'(len % BYTES) : '0;
        fifo_q.push_back(e.d);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic clear_sb();
    exp_q.delete(); got.delete(); acc_cyc.delete(); fifo_q.delete();
    first_rden = -1; first_valid = -1; err_cycles = 0; err_rises = 0;
    rd_empty_viol = 1'b0;
  endtask

  task automatic wait_drain(input int budget, output bit ok);
    int n = 0;
    while ((fifo_q.size() != 0 || got.size() < exp_q.size()) && n < budget) begin
      @(negedge clk);
      n++;
    end
    ok = (n < budget);
    repeat (6) @(negedge clk);
    #4;
  endtask

  function automatic int first_bad();
    int n = (got.size() > exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      if (i >= got.size() || i >= exp_q.size() || got[i] !== exp_q[i]) return i;
    return -1;
  endfunction

  function automatic word_t pick(input word_t q[$], input int i);
    if (i >= 0 && i < q.size()) return q[i];
    return 'x;
  endfunction

  task automatic test_reset();
    #1 reset_ = 1'b0;
    clear_sb();
    fifo_q.push_back(rand_word());
    repeat (2) @(negedge clk);
    #2;
    n_checks++;
    if ({fifo_rden, tx_valid, tx_sop, tx_eop, tx_mod, len_err} !== '0)
      $display("FAIL reset_ctrl: got %b required 0", {fifo_rden, tx_valid, tx_sop, tx_eop, tx_mod, len_err});
    else n_pass++;
    n_checks++;
    if (tx_data !== '0) $display("FAIL reset_data: got %h required 0", tx_data);
    else n_pass++;
    fifo_q.delete();
    repeat (2) @(negedge clk);
    reset_ = 1'b1;
  endtask

  task automatic test_64byte();
    bit ok; int idx;
    clear_sb();
    tx_ready = 1'b1;
    push_pkt(64);
    wait_drain(100, ok);
    n_checks++;
    if (!ok) $display("FAIL p64_timeout: got %0d words required %0d", got.size(), exp_q.size());
    else n_pass++;
    idx = first_bad();
    n_checks++;
    if (idx >= 0) $display("FAIL p64_stream: word %0d got %h required %h (counts %0d/%0d)",
                           idx, pick(got, idx), pick(exp_q, idx), got.size(), exp_q.size());
    else n_pass++;
    n_checks++;
    if (first_valid - first_rden !== 3)
      $display("FAIL p64_latency: got %0d cycles required 3", first_valid - first_rden);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    bit ok; int idx; int g0; int g1;
    clear_sb();
    tx_ready = 1'b1;
    push_pkt(1);
    push_pkt(33);
    wait_drain(100, ok);
    n_checks++;
    if (!ok) $display("FAIL b2b_timeout: got %0d words required %0d", got.size(), exp_q.size());
    else n_pass++;
    idx = first_bad();
    n_checks++;
    if (idx >= 0) $display("FAIL b2b_stream: word %0d got %h required %h (counts %0d/%0d)",
                           idx, pick(got, idx), pick(exp_q, idx), got.size(), exp_q.size());
    else n_pass++;
    g0 = (acc_cyc.size() == 3) ? acc_cyc[1] - acc_cyc[0] : -1;
    g1 = (acc_cyc.size() == 3) ? acc_cyc[2] - acc_cyc[1] : -1;
    n_checks++;
    if (g0 !== 2) $display("FAIL b2b_bubble: got spacing %0d required 2", g0);
    else n_pass++;
    n_checks++;
    if (g1 !== 1) $display("FAIL b2b_stream_rate: got spacing %0d required 1", g1);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    bit ok; int idx; int span; int n;
    int hold_bad = 0; int rden_late = 0; int occ_bad = 0;
    logic [WIDTH+MOD_W+2:0] snap;
    clear_sb();
    tx_ready = 1'b1;
    push_pkt(300);
    wait_drain(100, ok);
    span = (acc_cyc.size() == 10) ? acc_cyc[9] - acc_cyc[0] : -1;
    n_checks++;
    if (!ok || span !== 9) $display("FAIL bp_full_rate: got span %0d required 9", span);
    else n_pass++;
    idx = first_bad();
    n_checks++;
    if (idx >= 0) $display("FAIL bp_stream1: word %0d got %h required %h (counts %0d/%0d)",
                           idx, pick(got, idx), pick(exp_q, idx), got.size(), exp_q.size());
    else n_pass++;

    clear_sb();
    push_pkt(300);
    n = 0;
    while (got.size() < 3 && n < 100) begin
      @(negedge clk); #4; n++;
    end
    @(negedge clk);
    tx_ready = 1'b0;
    #3;
    snap = {tx_data, tx_sop, tx_eop, tx_mod};
    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin
        @(negedge clk); #3;
      end
      if (tx_valid !== 1'b1 || {tx_data, tx_sop, tx_eop, tx_mod} !== snap) hold_bad++;
      if (i >= 2 && fifo_rden) rden_late++;
      if (dut.occ > 2'd2) occ_bad++;
    end
    n_checks++;
    if (hold_bad !== 0) $display("FAIL bp_hold: got %0d unstable cycles required 0", hold_bad);
    else n_pass++;
    n_checks++;
    if (rden_late !== 0) $display("FAIL bp_rden_stop: got %0d late reads required 0", rden_late);
    else n_pass++;
    n_checks++;
    if (occ_bad !== 0) $display("FAIL bp_occ: got %0d overflow cycles required 0", occ_bad);
    else n_pass++;
    @(negedge clk);
    tx_ready = 1'b1;
    wait_drain(200, ok);
    n_checks++;
    if (!ok) $display("FAIL bp_timeout: got %0d words required %0d", got.size(), exp_q.size());
    else n_pass++;
    idx = first_bad();
    n_checks++;
    if (idx >= 0) $display("FAIL bp_stream2: word %0d got %h required %h (counts %0d/%0d)",
                           idx, pick(got, idx), pick(exp_q, idx), got.size(), exp_q.size());
    else n_pass++;
  endtask

  task automatic test_empty_gaps();
    int idx; int n = 0;
    clear_sb();
    tx_ready = 1'b1;
    push_pkt(150);
    while ((fifo_q.size() != 0 || got.size() < exp_q.size()) && n < 200) begin
      @(negedge clk);
      gap = ~gap;
      n++;
    end
    gap = 1'b0;
    repeat (6) @(negedge clk);
    #4;
    n_checks++;
    if (n >= 200) $display("FAIL gap_timeout: got %0d words required %0d", got.size(), exp_q.size());
    else n_pass++;
    idx = first_bad();
    n_checks++;
    if (idx >= 0) $display("FAIL gap_stream: word %0d got %h required %h (counts %0d/%0d)",
                           idx, pick(got, idx), pick(exp_q, idx), got.size(), exp_q.size());
    else n_pass++;
    n_checks++;
    if (rd_empty_viol !== 1'b0) $display("FAIL gap_read_empty: got %0d required 0", rd_empty_viol);
    else n_pass++;
  endtask

  task automatic test_illegal();
    bit ok; int idx;
    clear_sb();
    tx_ready = 1'b1;
    push_pkt(0);
    repeat (5) @(negedge clk);
    push_pkt(MAX_LEN + 1);
    repeat (5) @(negedge clk);
    push_pkt(32);
    wait_drain(100, ok);
    n_checks++;
    if (err_cycles !== 2) $display("FAIL ill_err_cycles: got %0d required 2", err_cycles);
    else n_pass++;
    n_checks++;
    if (err_rises !== 2) $display("FAIL ill_err_pulses: got %0d required 2", err_rises);
    else n_pass++;
    idx = first_bad();
    n_checks++;
    if (!ok || idx >= 0) $display("FAIL ill_stream: word %0d got %h required %h (counts %0d/%0d)",
                                  idx, pick(got, idx), pick(exp_q, idx), got.size(), exp_q.size());
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit ok; int idx; int n = 0;
    clear_sb();
    tx_ready = 1'b0;
    push_pkt(256);
    do begin
      @(negedge clk); #2; n++;
    end while (dut.occ != 2'd2 && n < 50);
    n_checks++;
    if (dut.occ !== 2'd2) $display("FAIL rst_fill: got occ %0d required 2", dut.occ);
    else n_pass++;
    reset_ = 1'b0;
    #1;
    n_checks++;
    if ({fifo_rden, tx_valid, tx_sop, tx_eop, tx_mod, len_err, tx_data} !== '0)
      $display("FAIL rst_async: got %b/%h required all 0",
               {fifo_rden, tx_valid, tx_sop, tx_eop, tx_mod, len_err}, tx_data);
    else n_pass++;
    @(negedge clk);
    clear_sb();
    repeat (2) @(negedge clk);
    reset_ = 1'b1;
    tx_ready = 1'b1;
    push_pkt($urandom_range(1, 400));
    wait_drain(200, ok);
    n_checks++;
    if (!ok) $display("FAIL rst_timeout: got %0d words required %0d", got.size(), exp_q.size());
    else n_pass++;
    idx = first_bad();
    n_checks++;
    if (idx >= 0) $display("FAIL rst_stream: word %0d got %h required %h (counts %0d/%0d)",
                           idx, pick(got, idx), pick(exp_q, idx), got.size(), exp_q.size());
    else n_pass++;
  endtask

  task automatic test_random();
    int idx; int n = 0; int n_bad = 0; int len; int r;
    clear_sb();
    for (int p = 0; p < 25; p++) begin
      r = $urandom_range(0, 9);
      if (p == 3) len = MAX_LEN;
      else if (r == 0) begin
        len = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(MAX_LEN + 1, 65535));
        n_bad++;
      end else len = $urandom_range(1, 600);
      push_pkt(len);
    end
    while ((fifo_q.size() != 0 || got.size() < exp_q.size()) && n < 20000) begin
      @(negedge clk);
      tx_ready = ($urandom_range(0, 3) != 0);
      gap = ($urandom_range(0, 4) == 0);
      n++;
    end
    tx_ready = 1'b1;
    gap = 1'b0;
    repeat (6) @(negedge clk);
    #4;
    n_checks++;
    if (n >= 20000) $display("FAIL rnd_timeout: got %0d words required %0d", got.size(), exp_q.size());
    else n_pass++;
    idx = first_bad();
    n_checks++;
    if (idx >= 0) $display("FAIL rnd_stream: word %0d got %h required %h (counts %0d/%0d)",
                           idx, pick(got, idx), pick(exp_q, idx), got.size(), exp_q.size());
    else n_pass++;
    n_checks++;
    if (err_cycles !== n_bad) $display("FAIL rnd_len_err: got %0d required %0d", err_cycles, n_bad);
    else n_pass++;
    n_checks++;
    if (rd_empty_viol !== 1'b0) $display("FAIL rnd_read_empty: got %0d required 0", rd_empty_viol);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_64byte();
    test_back_to_back();
    test_backpressure();
    test_empty_gaps();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/pkt_rd_framer.md
# pkt_rd_framer

Single-clock read-side framer on the packet FIFO's read port; its clock is the FIFO's `rdclk`. It pulls 256-bit words from the FIFO with a registered-read (1-cycle) handshake and treats the first word of each packet as a header carrying the byte length. It strips that header and emits payload words on a valid/ready stream with `sop`/`eop`/`mod` marking. A 2-entry output buffer with credit-based read issue gives full-rate streaming and lossless backpressure.

## Interface
- `WIDTH`, 256, data word width in bits.
- `MOD_W`, 5, width of `tx_mod`; equals log2(WIDTH/8).
- `LEN_W`, 16, width of the header length field.
- `MAX_LEN`, 9600, largest legal packet length in bytes.
- `clk`  in  1  block clock; the FIFO `rdclk`.
- `reset_`  in  1  reset, asynchronous assert, active-low.
- `fifo_rden`  out  1  FIFO read request.
- `fifo_dout`  in  WIDTH  FIFO read data; valid the cycle after `fifo_rden`.
- `fifo_rdempty`  in  1  FIFO empty flag.
- `tx_valid`  out  1  output word valid.
- `tx_ready`  in  1  downstream accept.
- `tx_data`  out  WIDTH  payload word.
- `tx_sop`  out  1  first payload word of a packet.
- `tx_eop`  out  1  last payload word of a packet.
- `tx_mod`  out  MOD_W  valid bytes in the eop word; 0 means all WIDTH/8 bytes are valid. Meaningful only when `tx_eop`=1.
- `len_err`  out  1  one-cycle pulse when an illegal header is discarded.

## Operation
- **Read issue.** `fifo_rden` = !`fifo_rdempty` && ((occ − pop + inflight) < 2).
  - `occ` is buffer occupancy (0..2).
  - `pop` = `tx_valid` && `tx_ready`.
  - `inflight` is the registered value of the previous cycle's `fifo_rden`.
- **Word classifier.** Acts on returned data (the cycle `inflight`=1), not on issue.
  - `hdr_exp` = 1 after reset and after each eop word.
- **Header word** (`hdr_exp`=1): `len` = `fifo_dout[LEN_W-1:0]`; other bits are ignored.
  - Legal (1 ≤ `len` ≤ `MAX_LEN`):
    - `words_left` = (`len` + WIDTH/8 − 1) >> MOD_W.
    - `mod_q` = `len[MOD_W-1:0]`.
    - `first` = 1; `hdr_exp` = 0.
    - The header is not written to the buffer.
  - Illegal: `len_err` pulses for 1 cycle, the word is dropped, and `hdr_exp` stays 1. The next word is taken as a header; the upstream writer is responsible for framing integrity.
- **Payload word** (`hdr_exp`=0): written to the buffer tagged with:
  - `sop` = `first`.
  - `eop` = (`words_left` == 1).
  - `mod` = `mod_q` if eop, else 0.
  - Then `first` = 0 and `words_left` decrements. On eop, `hdr_exp` = 1.
- **Buffer.** 2-entry FIFO, oldest entry at the head.
  - `tx_*` are driven from the head entry; `tx_valid` = (occ ≠ 0).
  - Push and pop in the same cycle: occ is unchanged and order is preserved.
  - Overflow cannot occur by construction; the bench asserts this.
- **Backpressure.** While `tx_valid`=1 and `tx_ready`=0, `tx_data`/`sop`/`eop`/`mod` hold stable.
- **Single-word packet** (`len` ≤ 32): the word carries `tx_sop`=`tx_eop`=1.

## Timing
- **Reset values** (asynchronous, while `reset_`=0): `fifo_rden`=0, `tx_valid`=0, `tx_sop`=0, `tx_eop`=0, `tx_mod`=0, `tx_data`=0, `len_err`=0. Internally occ=0, `inflight`=0, `hdr_exp`=1.
- **Reset mid-packet** discards the buffer and the in-flight word. The FIFO itself is not reset by this block.
- **Latency.** `fifo_rden` at cycle T → word classified at T+1 → `tx_valid` at T+2 (registered buffer output). Minimum latency from a header read to the first payload on `tx_valid` is 3 cycles.
- **Throughput.**
  - Steady state is 1 payload word per cycle with `tx_ready`=1.
  - Each header costs exactly one bubble cycle.
  - Back-to-back packets sustain N/(N+1) words per cycle.
- **Boundaries.**
  - `fifo_rdempty` asserted mid-packet: reads stall, state is held, and the output drains. Resumption is seamless.
  - `tx_ready`=0 with occ=2: `fifo_rden`=0 until a pop.
  - `len` = `MAX_LEN` is legal; `len` = `MAX_LEN`+1 and `len` = 0 are errors.
  - `words_left` is LEN_W − MOD_W + 1 bits wide. Its maximum value is (`MAX_LEN`+31)>>5 = 300.

## Test plan
- **64-byte packet.** FIFO holds header `len`=64 plus 2 words, `tx_ready`=1 → 2 outputs.
  - Word 0: `sop`=1, `eop`=0.
  - Word 1: `eop`=1, `mod`=0.
  - `tx_valid` first rises 3 cycles after the first `fifo_rden`.
- **1-byte and 33-byte packets back to back.**
  - 1-byte: a single word with `sop`=`eop`=1, `mod`=1.
  - 33-byte: 2 words, last with `mod`=1.
  - Exactly one bubble between the packets.
- **Streaming and backpressure.** 10-word packet, `tx_ready`=1 → 10 consecutive `tx_valid` cycles. Then `tx_ready`=0 for 8 cycles mid-packet:
  - `fifo_rden` drops within 2 cycles.
  - occ ≤ 2 throughout.
  - Data is held stable; no word is lost or duplicated.
- **Empty gaps.** `fifo_rdempty` toggled every other cycle during a 5-word packet → the 5 words are delivered in order with correct `sop`/`eop`.
- **Illegal headers.** Header `len`=0, then header `len`=9601, then a legal 32-byte packet:
  - 2 single-cycle `len_err` pulses.
  - No output for the bad headers.
  - The legal packet is emitted with `sop`=`eop`=1, `mod`=0.
- **Reset mid-packet.** Assert `reset_`=0 asynchronously mid-packet with occ=2 → all outputs are 0 immediately. After release, the next FIFO word is treated as a header.
